console_fetch_arbiter: RTL and testbench

Shares the single-port character RAM of the VGA text console between the video fetch path and the CPU peripheral bus. Takes the sync generator's `hpos`/`vpos` and schedules one video fetch slot per 16-pixel character cell, so the glyph code for each cell is ready exactly when its first pixel is drawn. All remaining RAM cycles go to CPU reads and writes through a req/ready handshake. The block sits between the sync generator, the character RAM and the peripheral register interface.

---
 rtl/console_fetch_arbiter.sv | 153 +++++++++++++++
 tb/tb_console_fetch_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/console_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : console_fetch_arbiter
// Brief   : Shares the text-console character RAM between video fetch and CPU.
// Revision: 1.0
// ============================================================================
module console_fetch_arbiter #(
   parameter int COLS  = 40,
   parameter int ROWS  = 30,
   parameter int H_MAX = 799,
   parameter int V_MAX = 524
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [9:0]  hpos,
   input  logic [9:0]  vpos,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [10:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_ready,
   output logic [7:0]  cpu_rdata,
   output logic        ram_en,
   output logic        ram_we,
   output logic [10:0] ram_addr,
   output logic [7:0]  ram_wdata,
   input  logic [7:0]  ram_rdata,
   output logic [7:0]  char_code
);

   localparam logic [6:0]  COLS_W = 7'(COLS);
   localparam logic [9:0]  LINES  = 10'(ROWS * 16);
   localparam logic [10:0] CELLS  = 11'(COLS * ROWS);
   localparam logic [9:0]  H_WRAP = 10'(H_MAX - 1);
   localparam logic [9:0]  V_LAST = 10'(V_MAX);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        slot;
   logic        fetch_issue;
   logic        fetch_pend;
   logic [6:0]  tgt_col;
   logic [9:0]  tgt_line;
   logic [5:0]  tgt_row;
   logic [10:0] tgt_addr;
   logic        grant;
   logic        addr_oor;
   logic        cpu_acc;
   logic        cap_read;
   logic        cap_oor;

   // The slot two pixels before a cell fetches that cell; the last slot of a
   // line looks ahead to column 0 of the next line.
   always_comb begin
      tgt_col  = 7'd0;
      tgt_line = vpos;
      if (hpos == H_WRAP) begin
         tgt_line = (vpos == V_LAST) ? 10'd0 : vpos + 10'd1;
      end else begin
         tgt_col = {1'b0, hpos[9:4]} + 7'd1;
      end
   end

   assign tgt_row     = tgt_line[9:4];
   assign slot        = (hpos[3:0] == 4'd14);
   assign fetch_issue = slot && (tgt_col < COLS_W) && (tgt_line < LINES);

   generate
      if (COLS == 40) begin : g_addr_shift
         assign tgt_addr = {tgt_row, 5'b0} + {2'b0, tgt_row, 3'b0} + {4'b0, tgt_col};
      end else begin : g_addr_mul
         assign tgt_addr = 11'(tgt_row * COLS) + {4'b0, tgt_col};
      end
   endgenerate

   assign addr_oor = (cpu_addr >= CELLS);
   assign cpu_acc  = grant & ~addr_oor;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cpu_req && !slot) begin
               grant     = 1'b1;
               state_nxt = ST_CAPTURE;
            end
         end
         ST_CAPTURE: state_nxt = ST_DONE;
         ST_DONE:    state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // Video and CPU can never collide: a grant is suppressed on every slot.
   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = 11'd0;
      ram_wdata = 8'd0;
      if (rst_n) begin
         if (fetch_issue) begin
            ram_en   = 1'b1;
            ram_addr = tgt_addr;
         end else if (cpu_acc) begin
            ram_en    = 1'b1;
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_read   <= 1'b0;
         cap_oor    <= 1'b0;
         cpu_ready  <= 1'b0;
         cpu_rdata  <= 8'h00;
         fetch_pend <= 1'b0;
         char_code  <= 8'h00;
      end else begin
         if (grant) begin
            cap_read <= ~cpu_we;
            cap_oor  <= addr_oor;
         end
         cpu_ready <= (state == ST_CAPTURE);
         if ((state == ST_CAPTURE) && cap_read) begin
            cpu_rdata <= cap_oor ? 8'h00 : ram_rdata;
         end
         fetch_pend <= fetch_issue;
         if (fetch_pend) begin
            char_code <= ram_rdata;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_console_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_console_fetch_arbiter
// Brief   : Directed bench with a cell-level reference model of console_fetch_arbiter.
// Revision: 1.0
// ============================================================================
module tb_console_fetch_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  hpos;
   logic [9:0]  vpos;
   logic        cpu_req;
   logic        cpu_we;
   logic [10:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ready;
   logic [7:0]  cpu_rdata;
   logic        ram_en;
   logic        ram_we;
   logic [10:0] ram_addr;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata = 8'h00;
   logic [7:0]  char_code;

   always #5 clk = ~clk;

   console_fetch_arbiter #(.COLS(40), .ROWS(30), .H_MAX(799), .V_MAX(524)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .hpos      (hpos),
      .vpos      (vpos),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_ready (cpu_ready),
      .cpu_rdata (cpu_rdata),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .char_code (char_code)
   );

   // Character RAM, preloaded with cell i = i[7:0]
   logic [7:0] mem [0:2047];
   bit         preloaded = 1'b0;
   always @(posedge clk) begin
      if (!preloaded) begin
         for (int i = 0; i < 2048; i++) mem[i] = i[7:0];
         preloaded = 1'b1;
      end
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         ram_rdata <= mem[ram_addr];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int phase = 0;
   int jump_cycle = 0;
   int timeouts = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d (h=%0d v=%0d): got %0d expected %0d",
                  name, cyc, hpos, vpos, act, exp);
      end
   endtask

   // Reference model: what the port and CPU side must show, by cell geometry
   // and transaction timing (grant when free and not a slot, ready 2 later).
   logic [7:0] ref_mem [0:2047];
   bit  ref_loaded = 1'b0;
   bit  final_done = 1'b0;
   int  free_at = 0;
   int  ready_at = -1;
   int  exp_rdata = 0;
   int  tx_data = 0;
   bit  tx_we = 1'b0;
   int  rst_cycle = 0;

   always @(negedge clk) begin
      int h, v, line, col, vaddr;
      bit vid, acc, grant;
      if (!ref_loaded) begin
         for (int i = 0; i < 2048; i++) ref_mem[i] = i[7:0];
         ref_loaded = 1'b1;
      end
      h = int'(hpos);
      v = int'(vpos);
      if (!rst_n) begin
         free_at   = cyc + 1;
         ready_at  = -1;
         exp_rdata = 0;
         rst_cycle = cyc;
         chk("rst_ram_en", int'(ram_en), 0);
         chk("rst_cpu_ready", int'(cpu_ready), 0);
         chk("rst_cpu_rdata", int'(cpu_rdata), 0);
         chk("rst_char_code", int'(char_code), 0);
      end else begin
         vid = 1'b0;
         vaddr = 0;
         if (h % 16 == 14) begin
            if (h == 798) begin
               line = (v == 524) ? 0 : v + 1;
               col  = 0;
            end else begin
               line = v;
               col  = h / 16 + 1;
            end
            if (col < 40 && line < 480) begin
               vid   = 1'b1;
               vaddr = (line / 16) * 40 + col;
            end
         end
         grant = cpu_req && (cyc >= free_at) && (h % 16 != 14);
         acc = 1'b0;
         if (grant) begin
            tx_we    = cpu_we;
            ready_at = cyc + 2;
            free_at  = cyc + 3;
            acc      = (cpu_addr < 11'd1200);
            tx_data  = acc ? int'(ref_mem[cpu_addr]) : 0;
            if (acc && cpu_we) ref_mem[cpu_addr] = cpu_wdata;
         end
         if (cyc == ready_at && !tx_we) exp_rdata = tx_data;

         chk("ram_en", int'(ram_en), int'(vid | acc));
         chk("ram_we", int'(ram_we), int'(acc & cpu_we));
         if (vid) chk("ram_addr_video", int'(ram_addr), vaddr);
         if (acc) chk("ram_addr_cpu", int'(ram_addr), int'(cpu_addr));
         if (acc && cpu_we) chk("ram_wdata", int'(ram_wdata), int'(cpu_wdata));
         chk("cpu_ready", int'(cpu_ready), int'(cyc == ready_at));
         chk("cpu_rdata", int'(cpu_rdata), exp_rdata);
         if (h % 16 <= 13 && h / 16 < 40 && v < 480 &&
             cyc - jump_cycle >= 17 && cyc - rst_cycle >= 17)
            chk("char_code", int'(char_code), int'(ref_mem[(v / 16) * 40 + h / 16]));

         // Hand-computed pins
         if (h == 798 && v == 16) begin
            chk("pin_l16_en", int'(ram_en), 1);
            chk("pin_l16_addr", int'(ram_addr), 40);
         end
         if (h == 0   && v == 17) chk("pin_char_h0", int'(char_code), 40);
         if (h == 16  && v == 17) chk("pin_char_h16", int'(char_code), 41);
         if (h == 624 && v == 17) chk("pin_char_h624", int'(char_code), 79);
         if (h == 638 && v == 17) chk("pin_col40_en", int'(ram_en), 0);
         if (h == 798 && v == 524) begin
            chk("pin_wrap_en", int'(ram_en), 1);
            chk("pin_wrap_addr", int'(ram_addr), 0);
         end
         if (h == 16 && v == 0) chk("pin_char_l0", int'(char_code), 1);
         if (h == 798 && v == 478) begin
            chk("pin_l479_en", int'(ram_en), 1);
            chk("pin_l479_addr", int'(ram_addr), 1160);
         end
         if (h == 798 && v == 479) chk("pin_l480_en", int'(ram_en), 0);
         if (phase == 1 && h == 30) chk("pin_stall_we", int'(ram_we), 0);
         if (phase == 1 && h == 31) begin
            chk("pin_grant_we", int'(ram_we), 1);
            chk("pin_grant_addr", int'(ram_addr), 100);
            chk("pin_grant_wdata", int'(ram_wdata), 8'hA5);
         end
         if (phase == 6 && h == 80) chk("pin_oor_en", int'(ram_en), 0);
         if (cpu_ready) begin
            case (phase)
               1: chk("pin_wr_ready_h", h, 33);
               2: begin chk("pin_rd_ready_h", h, 36); chk("pin_rd_data", int'(cpu_rdata), 8'hA5); end
               3: begin chk("pin_b2b0_h", h, 50); chk("pin_b2b0_data", int'(cpu_rdata), 40); end
               4: begin chk("pin_b2b1_h", h, 53); chk("pin_b2b1_data", int'(cpu_rdata), 41); end
               5: begin chk("pin_b2b2_h", h, 56); chk("pin_b2b2_data", int'(cpu_rdata), 42); end
               6: begin chk("pin_oor_ready_h", h, 82); chk("pin_oor_data", int'(cpu_rdata), 0); end
               8: begin chk("pin_rst_ready_h", h, 114); chk("pin_rst_data", int'(cpu_rdata), 45); end
               default: ;
            endcase
         end
      end
      if (phase == 9 && !final_done) begin
         chk("oor_write_ram", int'(mem[2047]), 8'hFF);
         chk("timeouts", timeouts, 0);
         final_done = 1'b1;
      end
   end

   task automatic adv();
      @(posedge clk);
      #1;
      if (hpos == 10'd799) begin
         hpos = 10'd0;
         vpos = (vpos == 10'd524) ? 10'd0 : vpos + 10'd1;
      end else begin
         hpos = hpos + 10'd1;
      end
   endtask

   task automatic jump(input int h, input int v);
      @(posedge clk);
      #1;
      hpos = 10'(h);
      vpos = 10'(v);
      jump_cycle = cyc;
   endtask

   task automatic run_to(input int h, input int v);
      int n = 0;
      while (!(int'(hpos) == h && int'(vpos) == v) && n < 2000) begin
         adv();
         n++;
      end
      if (n >= 2000) timeouts++;
   endtask

   task automatic wait_ready();
      bit got = 1'b0;
      int n = 0;
      while (!got && n < 20) begin
         @(negedge clk);
         if (cpu_ready) got = 1'b1;
         else adv();
         n++;
      end
      if (!got) timeouts++;
   endtask

   initial begin
      rst_n = 1'b0;
      hpos = 10'd0;
      vpos = 10'd0;
      cpu_req = 1'b0;
      cpu_we = 1'b0;
      cpu_addr = 11'd0;
      cpu_wdata = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      jump(790, 16);
      run_to(30, 17);
      phase = 1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'd100; cpu_wdata = 8'hA5;
      wait_ready(); adv();
      phase = 2; cpu_we = 1'b0; cpu_addr = 11'd100;
      wait_ready(); adv();
      cpu_req = 1'b0;

      run_to(48, 17);
      phase = 3; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'd40;
      wait_ready(); adv();
      phase = 4; cpu_addr = 11'd41;
      wait_ready(); adv();
      phase = 5; cpu_addr = 11'd42;
      wait_ready(); adv();
      cpu_req = 1'b0;

      run_to(80, 17);
      phase = 6; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'd1200;
      wait_ready(); adv();
      cpu_req = 1'b0;
      run_to(88, 17);
      phase = 7; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'd2047; cpu_wdata = 8'h3C;
      wait_ready(); adv();
      cpu_req = 1'b0;

      run_to(109, 17);
      phase = 8; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'd45;
      adv(); rst_n = 1'b0;
      adv();
      adv(); rst_n = 1'b1;
      wait_ready(); adv();
      cpu_req = 1'b0;

      run_to(624, 17);
      run_to(638, 17);
      jump(790, 524);
      run_to(16, 0);
      jump(790, 478);
      run_to(798, 478);
      jump(790, 479);
      run_to(798, 479);
      adv();
      phase = 9;
      adv();
      adv();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
